// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: restart PC,
// payload field widths/offsets and the packed M/W payload layout.
package pipe_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam int ALUOP_W    = 8;
  localparam int REGA3_W    = 5;
  localparam int REGWDSEL_W = 4;
  localparam int WORD_W     = 32;
  localparam int STAGE_DATA_W = 128;

  // Offsets are measured from bit 0 of the packed M/W payload.
  localparam int MW_ALURES_OFS   = 0;
  localparam int MW_MEMDATA_OFS  = MW_ALURES_OFS + WORD_W;
  localparam int MW_HILO_OFS     = MW_MEMDATA_OFS + WORD_W;
  localparam int MW_REGWDSEL_OFS = MW_HILO_OFS + WORD_W;
  localparam int MW_REGA3_OFS    = MW_REGWDSEL_OFS + REGWDSEL_W;
  localparam int MW_ALUOP_OFS    = MW_REGA3_OFS + REGA3_W;
  localparam int MW_USED_W       = MW_ALUOP_OFS + ALUOP_W;
  localparam int MW_PAD_W        = STAGE_DATA_W - MW_USED_W;

  typedef struct packed {
    logic [MW_PAD_W-1:0]   pad;
    logic [ALUOP_W-1:0]    aluOp;
    logic [REGA3_W-1:0]    regA3;
    logic [REGWDSEL_W-1:0] regWdSel;
    logic [WORD_W-1:0]     hiLo;
    logic [WORD_W-1:0]     memData;
    logic [WORD_W-1:0]     aluResult;
  } mwPayload_t;

  function automatic mwPayload_t mwPack(
    input logic [ALUOP_W-1:0]    aluOp,
    input logic [REGA3_W-1:0]    regA3,
    input logic [REGWDSEL_W-1:0] regWdSel,
    input logic [WORD_W-1:0]     hiLo,
    input logic [WORD_W-1:0]     memData,
    input logic [WORD_W-1:0]     aluResult
  );
    mwPayload_t p;
    p           = '0;
    p.aluOp     = aluOp;
    p.regA3     = regA3;
    p.regWdSel  = regWdSel;
    p.hiLo      = hiLo;
    p.memData   = memData;
    p.aluResult = aluResult;
    return p;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry (valid + PC + regwrite + payload) with load, drop and
// flush controls; flush restores the restart PC but leaves the payload alone.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W = 128,
  parameter int              PC_W   = 32,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_drop,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_regwrite,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_regwrite,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic              r_regwrite;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_pc       <= RST_PC;
      r_regwrite <= 1'b0;
      r_data     <= '0;
    end else if (i_flush) begin
      r_valid    <= 1'b0;
      r_pc       <= RST_PC;
      r_regwrite <= 1'b0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_pc       <= i_pc;
      r_regwrite <= i_regwrite;
      r_data     <= i_data;
    end else if (i_drop) begin
      r_valid    <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_pc       = r_pc;
  assign o_regwrite = r_regwrite;
  assign o_data     = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage register with valid/ready handshake, 2-entry skid buffer and
// flush-to-restart-PC. Optional counters enabled by PIPE_STAGE_STATS_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int              DATA_W   = 128,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT[PC_W-1:0]
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_regwrite,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_regwrite,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  logic              w_mainValid, w_mainRegwrite;
  logic [PC_W-1:0]   w_mainPc;
  logic [DATA_W-1:0] w_mainData;
  logic              w_skidValid, w_skidRegwrite;
  logic [PC_W-1:0]   w_skidPc;
  logic [DATA_W-1:0] w_skidData;

  logic              w_acc, w_drn;
  logic              w_mainLoad, w_mainDrop, w_skidLoad, w_skidDrop;
  logic [PC_W-1:0]   w_mainSrcPc;
  logic              w_mainSrcRegwrite;
  logic [DATA_W-1:0] w_mainSrcData;

  // in_ready comes straight from the skid valid flop, so back-pressure
  // never forms a combinational path from out_ready to upstream.
  assign in_ready = ~w_skidValid;
  assign w_acc    = in_valid & in_ready;
  assign w_drn    = w_mainValid & out_ready;

  // Main refills from skid when one is parked there, else from the input.
  assign w_mainLoad = w_skidValid ? w_drn : (w_acc & (~w_mainValid | w_drn));
  assign w_mainDrop = w_drn & ~w_mainLoad;
  assign w_skidLoad = w_acc & w_mainValid & ~w_drn;
  assign w_skidDrop = w_skidValid & w_drn;

  assign w_mainSrcPc       = w_skidValid ? w_skidPc       : in_pc;
  assign w_mainSrcRegwrite = w_skidValid ? w_skidRegwrite : in_regwrite;
  assign w_mainSrcData     = w_skidValid ? w_skidData     : in_data;

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .RST_PC (RESET_PC)
  ) u_main (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (flush),
    .i_load     (w_mainLoad),
    .i_drop     (w_mainDrop),
    .i_pc       (w_mainSrcPc),
    .i_regwrite (w_mainSrcRegwrite),
    .i_data     (w_mainSrcData),
    .o_valid    (w_mainValid),
    .o_pc       (w_mainPc),
    .o_regwrite (w_mainRegwrite),
    .o_data     (w_mainData)
  );

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .RST_PC ('0)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (flush),
    .i_load     (w_skidLoad),
    .i_drop     (w_skidDrop),
    .i_pc       (in_pc),
    .i_regwrite (in_regwrite),
    .i_data     (in_data),
    .o_valid    (w_skidValid),
    .o_pc       (w_skidPc),
    .o_regwrite (w_skidRegwrite),
    .o_data     (w_skidData)
  );

  assign out_valid    = w_mainValid;
  assign out_pc       = w_mainPc;
  assign out_regwrite = w_mainRegwrite & w_mainValid;
  assign out_data     = w_mainData;

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] r_stallCnt;
  logic [15:0] r_flushCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_mainValid && !out_ready && r_stallCnt != 16'hFFFF)
        r_stallCnt <= r_stallCnt + 16'd1;
      if (flush && r_flushCnt != 16'hFFFF)
        r_flushCnt <= r_flushCnt + 16'd1;
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a table of directed per-cycle
// vectors plus hand-written reset and counter sequences.
module tb_pipe_stage_skid;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_pc;
  logic         in_regwrite;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_pc;
  logic         out_regwrite;
  logic [127:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0]  stall_cnt;
  logic [15:0]  flush_cnt;
`endif

  int errCount;
  int checkCount;

  pipe_stage_skid dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_regwrite  (in_regwrite),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_regwrite (out_regwrite),
    .out_data     (out_data)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        flush;
    logic        inValid;
    logic [31:0] inPc;
    logic        inRegwrite;
    logic        outReady;
    logic        expValid;
    logic [31:0] expPc;
    logic        expRegwrite;
    logic        expInReady;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Payload is derived from the PC so data ordering is checked alongside it.
  task automatic applyStimulus(input vec_t v);
    flush       = v.flush;
    in_valid    = v.inValid;
    in_pc       = v.inPc;
    in_regwrite = v.inRegwrite;
    in_data     = {4{v.inPc}};
    out_ready   = v.outReady;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_pc       = 32'h0;
    in_regwrite = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    idleInputs();
    reset = 1'b1;

    //            name        fl iv  inPc          rw or  eV eP            eR rdy
    vecs[0]  = '{"stream0",  0, 1, 32'h3000, 1, 1, 1, 32'h3000, 1, 1};
    vecs[1]  = '{"stream1",  0, 1, 32'h3004, 0, 1, 1, 32'h3004, 0, 1};
    vecs[2]  = '{"stream2",  0, 1, 32'h3008, 1, 1, 1, 32'h3008, 1, 1};
    vecs[3]  = '{"drain",    0, 0, 32'h0000, 0, 1, 0, 32'h3008, 0, 1};
    vecs[4]  = '{"bpA",      0, 1, 32'h3010, 1, 0, 1, 32'h3010, 1, 1};
    vecs[5]  = '{"bpB",      0, 1, 32'h3014, 0, 0, 1, 32'h3010, 1, 0};
    vecs[6]  = '{"bpHold",   0, 1, 32'h3018, 1, 0, 1, 32'h3010, 1, 0};
    vecs[7]  = '{"bpOutB",   0, 0, 32'h0000, 0, 1, 1, 32'h3014, 0, 1};
    vecs[8]  = '{"bpEmpty",  0, 0, 32'h0000, 0, 1, 0, 32'h3014, 0, 1};
    vecs[9]  = '{"fillA",    0, 1, 32'h3030, 1, 0, 1, 32'h3030, 1, 1};
    vecs[10] = '{"fillB",    0, 1, 32'h3034, 0, 0, 1, 32'h3030, 1, 0};
    vecs[11] = '{"flushFull",1, 1, 32'h3020, 1, 0, 0, 32'h3000, 0, 1};
    vecs[12] = '{"postFlush",0, 0, 32'h0000, 0, 1, 0, 32'h3000, 0, 1};
    vecs[13] = '{"flushDrop",1, 1, 32'h3040, 1, 1, 0, 32'h3000, 0, 1};
    vecs[14] = '{"rwPush",   0, 1, 32'h3050, 1, 1, 1, 32'h3050, 1, 1};
    vecs[15] = '{"rwIdle0",  0, 0, 32'h0000, 0, 1, 0, 32'h3050, 0, 1};
    vecs[16] = '{"rwIdle1",  0, 0, 32'h0000, 0, 1, 0, 32'h3050, 0, 1};

    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("rstValid",   {127'h0, out_valid},    128'h0);
    checkOutput("rstPc",      {96'h0, out_pc},        128'h3000);
    checkOutput("rstRw",      {127'h0, out_regwrite}, 128'h0);
    checkOutput("rstData",    out_data,               128'h0);
    checkOutput("rstInReady", {127'h0, in_ready},     128'h1);
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, ".valid"},   {127'h0, out_valid},    {127'h0, vecs[i].expValid});
      checkOutput({vecs[i].name, ".pc"},      {96'h0, out_pc},        {96'h0, vecs[i].expPc});
      checkOutput({vecs[i].name, ".rw"},      {127'h0, out_regwrite}, {127'h0, vecs[i].expRegwrite});
      checkOutput({vecs[i].name, ".inReady"}, {127'h0, in_ready},     {127'h0, vecs[i].expInReady});
      if (vecs[i].expValid)
        checkOutput({vecs[i].name, ".data"}, out_data, {4{vecs[i].expPc}});
    end

    // Asynchronous reset mid-transfer: fill to FULL, then reset between edges.
    idleInputs();
    in_valid = 1'b1; in_pc = 32'h3060; in_regwrite = 1'b1; in_data = {4{32'h3060}};
    @(posedge clk); #1;
    in_pc = 32'h3064; in_data = {4{32'h3064}};
    @(posedge clk); #1;
    checkOutput("preRstInReady", {127'h0, in_ready}, 128'h0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncRstValid",   {127'h0, out_valid},    128'h0);
    checkOutput("asyncRstPc",      {96'h0, out_pc},        128'h3000);
    checkOutput("asyncRstRw",      {127'h0, out_regwrite}, 128'h0);
    checkOutput("asyncRstInReady", {127'h0, in_ready},     128'h1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

`ifdef PIPE_STAGE_STATS_EN
    checkOutput("statRstStall", {112'h0, stall_cnt}, 128'h0);
    checkOutput("statRstFlush", {112'h0, flush_cnt}, 128'h0);
    in_valid = 1'b1; in_pc = 32'h3070; in_data = {4{32'h3070}}; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("statStall5", {112'h0, stall_cnt}, 128'd5);
    checkOutput("statFlush2", {112'h0, flush_cnt}, 128'd2);
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3074; in_data = {4{32'h3074}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (65530) @(posedge clk);
    #1;
    checkOutput("statSat", {112'h0, stall_cnt}, 128'hFFFF);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("statSatHold", {112'h0, stall_cnt}, 128'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
